fhe_buffer_ram_mp: RTL and testbench
====================================

// Module: fhe_buffer_ram_mp
// PURPOSE
//  Parametrised multi-port lane-enabled buffer RAM for FHE ALU operand/twiddle staging.
//  - NR read ports, NW write ports; each word is ITEMS lanes of WIDTH bits with per-lane enables.
//  - Adds over prior buffers: read-valid tracking, selectable same-cycle write forwarding,
//    deterministic write-write collision resolution with counting, and an in-place clear engine.
// PARAMETERS
//  DEPTH           512                  words per memory
//  WIDTH           FSIZE                bits per lane
//  ITEMS           E                    lanes per word
//  NR              2                    read ports (1..4)
//  NW              2                    write ports (1..2)
//  READ_LATENCY    BUFFER_READ_LATENCY  cycles rden->rvalid (>=1)
//  BYPASS          1                    1 = same-cycle write forwarded to read; 0 = read-old
//  CLEAR_ON_RESET  1                    1 = zero memory after reset
//  DEPTHAD         $clog2(DEPTH)        address width
// PORTS
//  clk          in   1                 single clock, all logic on posedge
//  rstn         in   1                 synchronous active-low reset
//  rden         in   NR                per-port read request
//  raddr        in   NR*DEPTHAD        read addresses
//  wren         in   NW*ITEMS          per-port, per-lane write enable
//  waddr        in   NW*DEPTHAD        write addresses
//  wdata        in   NW*ITEMS*WIDTH    write data
//  clear_req    in   1                 pulse: start zeroing all words
//  rdata        out  NR*ITEMS*WIDTH    read data
//  rvalid       out  NR                rdata qualifier per port
//  busy         out  1                 clear in progress
//  wcollide     out  1                 registered: both write ports hit same addr+lane last cycle
//  collide_cnt  out  16                saturating count of collision cycles
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): rdata=0, rvalid=0, wcollide=0, collide_cnt=0, pipeline flushed.
//    Memory contents untouched by reset itself. State <= CLEAR (busy=1 next cycle) if
//    CLEAR_ON_RESET else IDLE (busy=0).
//  - FSM IDLE/CLEAR:
//    - IDLE->CLEAR on clear_req.
//    - CLEAR writes 0 to word clr_addr and increments it each cycle.
//    - CLEAR->IDLE after word DEPTH-1 written, so busy=1 for exactly DEPTH cycles.
//    - clear_req while CLEAR ignored. Reset mid-clear restarts per CLEAR_ON_RESET (clr_addr=0).
//  - While busy: rden and wren ignored. Dropped reads produce rvalid=0 at their slot.
//  - Read: rden[p] at cycle t -> rvalid[p]=1 and rdata[p] at t+READ_LATENCY.
//    Fully pipelined, one read per port per cycle. rdata holds last value when rvalid=0.
//  - Write: lane l of word waddr[w] updated at posedge when wren[w][l]; other lanes keep value.
//    Writes are visible to reads issued on the next cycle.
//  - Write-write collision: same address and same lane on ports 0 and 1 -> port 1 wins.
//    wcollide=1 the following cycle; collide_cnt+1, saturating at 16'hFFFF.
//  - Same-cycle read/write of same address:
//    - BYPASS=1: each enabled lane returns the winning write data; disabled lanes return stored data.
//    - BYPASS=0: all lanes return pre-write data.
//  - Address >= DEPTH (non-power-of-two DEPTH): write dropped; read returns 0 with rvalid=1.
// STRUCTURE
//  - FHE_ALU_PKG: add BufRamState_t enum {BR_IDLE, BR_CLEAR} and BR_CNT_W=16.
//    Reuses FSIZE, E, BUFFER_READ_LATENCY.
//  - Sub-module fhe_buffer_rd_pipe: READ_LATENCY-deep data+valid delay line with sync reset,
//    one per read port.
//  - Memory: one array, NW-port write merge per lane (port 1 priority), NR combinational
//    read taps into the pipes.
// TESTING
//  1 Reset, DEPTH=8, CLEAR_ON_RESET=1: busy=1 for 8 cycles, then read all addrs -> rdata=0,
//    rvalid exactly READ_LATENCY after each rden.
//  2 Write addr 5 lanes {0,2}=0xA, 0xC, then read addr 5 next cycle -> lanes 0/2 = 0xA/0xC,
//    others 0, after READ_LATENCY cycles.
//  3 Ports 0,1 both write addr 3 lane 1 (0x11, 0x22) -> stored 0x22; wcollide=1 next cycle;
//    collide_cnt=1.
//  4 Same-cycle write addr 7=0x55 and read addr 7: BYPASS=1 -> 0x55; BYPASS=0 -> prior 0x0.
//  5 clear_req after filling memory; reset asserted at clear cycle 3 -> restart; busy lasts
//    DEPTH cycles post-reset. Reads/writes during busy: rvalid=0, memory unchanged.
//  6 Back-to-back rden every cycle on all NR ports for 20 cycles -> 20 rvalid pulses per port
//    in order, correct data.

Source files
------------

// File: rtl/fhe_buffer_ram_mp_pkg.sv
// Shared types and defaults for the FHE ALU multi-port lane-enabled buffer RAM.
package fhe_buffer_ram_mp_pkg;
  localparam int FSIZE               = 8;
  localparam int E                   = 4;
  localparam int BUFFER_READ_LATENCY = 2;
  localparam int BR_CNT_W            = 16;

  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_CLEAR = 1'b1
  } BufRamState_t;
endpackage

// File: rtl/fhe_buffer_rd_pipe.sv
// Read-return delay line: LAT stages of data+valid; data only advances with its valid,
// so the last stage holds the most recent returned word.
module fhe_buffer_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o
);
  logic [LAT-1:0]         vld_pipe_q;
  logic [LAT-1:0][DW-1:0] dat_pipe_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= vld_i;
      if (vld_i) dat_pipe_q[0] <= data_i;
      for (int s = 1; s < LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
    end
  end

  assign vld_o  = vld_pipe_q[LAT-1];
  assign data_o = dat_pipe_q[LAT-1];
endmodule

// File: rtl/fhe_buffer_ram_mp.sv
// Multi-port lane-enabled buffer RAM: NR pipelined reads, NW lane-masked writes (port 1 wins),
// optional same-cycle write forwarding, collision counting and an in-place clear engine.
module fhe_buffer_ram_mp
  import fhe_buffer_ram_mp_pkg::*;
#(
  parameter int DEPTH          = 512,
  parameter int WIDTH          = FSIZE,
  parameter int ITEMS          = E,
  parameter int NR             = 2,
  parameter int NW             = 2,
  parameter int READ_LATENCY   = BUFFER_READ_LATENCY,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int DEPTHAD        = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NR-1:0]             rden,
  input  logic [NR*DEPTHAD-1:0]     raddr,
  input  logic [NW*ITEMS-1:0]       wren,
  input  logic [NW*DEPTHAD-1:0]     waddr,
  input  logic [NW*ITEMS*WIDTH-1:0] wdata,
  input  logic                      clear_req,
  output logic [NR*ITEMS*WIDTH-1:0] rdata,
  output logic [NR-1:0]             rvalid,
  output logic                      busy,
  output logic                      wcollide,
  output logic [BR_CNT_W-1:0]       collide_cnt
);
  localparam int LW = ITEMS * WIDTH;
  localparam int W1 = (NW > 1) ? 1 : 0;

  logic [NR-1:0][DEPTHAD-1:0]          ra;
  logic [NW-1:0][DEPTHAD-1:0]          wa;
  logic [NW-1:0][ITEMS-1:0]            wr_en;
  logic [NW-1:0][ITEMS-1:0][WIDTH-1:0] wd;
  logic [NW-1:0][ITEMS-1:0]            wr_act;
  logic [NR-1:0][ITEMS-1:0][WIDTH-1:0] stored;
  logic [NR-1:0][ITEMS-1:0][WIDTH-1:0] rd_tap;
  logic [NR-1:0]                       rd_go;
  logic                                clr_we;
  logic                                coll;

  assign ra    = raddr;
  assign wa    = waddr;
  assign wr_en = wren;
  assign wd    = wdata;

  // ---------------- clear engine FSM ----------------
  BufRamState_t        state_q, state_d;
  logic [DEPTHAD-1:0]  clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? BR_CLEAR : BR_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      BR_IDLE: if (clear_req) begin
        state_d    = BR_CLEAR;
        clr_addr_d = '0;
      end
      BR_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == DEPTHAD'(DEPTH - 1)) begin
          state_d    = BR_IDLE;
          clr_addr_d = '0;
        end
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == BR_CLEAR);
    clr_we = (state_q == BR_CLEAR);
  end

  // ---------------- storage ----------------
  always_comb begin
    wr_act = '0;
    for (int w = 0; w < NW; w++)
      if (!busy && (32'(wa[w]) < 32'(DEPTH))) wr_act[w] = wr_en[w];
  end

  // One array per lane so each lane takes its own pair of writes; the later port wins a tie.
  for (genvar l = 0; l < ITEMS; l++) begin : g_lane
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (rstn) begin
        if (clr_we) mem_q[clr_addr_q] <= '0;
        else begin
          if (wr_act[0][l]) mem_q[wa[0]] <= wd[0][l];
          if ((NW > 1) && wr_act[W1][l]) mem_q[wa[W1]] <= wd[W1][l];
        end
      end
    end

    for (genvar p = 0; p < NR; p++) begin : g_tap
      assign stored[p][l] = mem_q[ra[p]];
    end
  end

  always_comb begin
    rd_tap = '0;
    for (int p = 0; p < NR; p++) begin
      if (32'(ra[p]) < 32'(DEPTH)) begin
        rd_tap[p] = stored[p];
        if (BYPASS != 0)
          for (int w = 0; w < NW; w++)
            for (int l = 0; l < ITEMS; l++)
              if (wr_act[w][l] && (wa[w] == ra[p])) rd_tap[p][l] = wd[w][l];
      end
    end
  end

  assign rd_go = rden & {NR{~busy}};

  for (genvar p = 0; p < NR; p++) begin : g_rd
    fhe_buffer_rd_pipe #(
      .DW  (LW),
      .LAT (READ_LATENCY)
    ) u_rd_pipe (
      .clk    (clk),
      .rstn   (rstn),
      .vld_i  (rd_go[p]),
      .data_i (rd_tap[p]),
      .vld_o  (rvalid[p]),
      .data_o (rdata[p*LW +: LW])
    );
  end

  // ---------------- write-write collision tracking ----------------
  if (NW > 1) begin : g_coll
    assign coll = !busy && (wa[0] == wa[W1]) && |(wr_en[0] & wr_en[W1]);
  end else begin : g_nocoll
    assign coll = 1'b0;
  end

  logic                wcollide_q;
  logic [BR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (coll && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcollide_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wcollide_q <= coll;
      cnt_q      <= cnt_d;
    end
  end

  assign wcollide    = wcollide_q;
  assign collide_cnt = cnt_q;
endmodule

// File: tb/tb_fhe_buffer_ram_mp.sv
// Randomized bench for fhe_buffer_ram_mp against a queue-based behavioural model.
module tb_fhe_buffer_ram_mp;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int W     = 8;
  localparam int IT    = 4;
  localparam int L     = 2;
  localparam int BYP   = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  rden = '0;
  logic [5:0]  raddr = '0;
  logic [7:0]  wren = '0;
  logic [5:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic        clear_req = 1'b0;
  logic [63:0] rdata;
  logic [1:0]  rvalid;
  logic        busy;
  logic        wcollide;
  logic [15:0] collide_cnt;

  fhe_buffer_ram_mp #(
    .DEPTH(DEPTH), .WIDTH(W), .ITEMS(IT), .NR(2), .NW(2),
    .READ_LATENCY(L), .BYPASS(BYP), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rstn(rstn), .rden(rden), .raddr(raddr), .wren(wren), .waddr(waddr),
    .wdata(wdata), .clear_req(clear_req), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .wcollide(wcollide), .collide_cnt(collide_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mm [DEPTH][IT];
  int          busy_cnt = 0;
  logic        qv [2][$];
  logic [31:0] qd [2][$];
  logic [31:0] exp_rdata [2];
  logic        exp_rvalid [2];
  logic        exp_wc = 1'b0;
  int          exp_cnt = 0;

  initial foreach (mm[a, l]) mm[a][l] = '0;

  always @(posedge clk) begin
    logic        bsy, v, cl;
    logic [31:0] d;
    int          a;
    if (!rstn) begin
      for (int p = 0; p < 2; p++) begin
        qv[p].delete(); qd[p].delete();
        for (int k = 0; k < L - 1; k++) begin qv[p].push_back(1'b0); qd[p].push_back('0); end
        exp_rdata[p] = '0; exp_rvalid[p] = 1'b0;
      end
      exp_wc = 1'b0; exp_cnt = 0; busy_cnt = DEPTH;
    end else begin
      bsy = (busy_cnt > 0);
      for (int p = 0; p < 2; p++) begin
        v = rden[p] && !bsy;
        d = '0;
        if (v) begin
          a = int'(raddr[p*AW +: AW]);
          for (int l = 0; l < IT; l++) begin
            d[l*W +: W] = mm[a][l];
            if (BYP != 0)
              for (int w = 0; w < 2; w++)
                if (wren[w*IT + l] && int'(waddr[w*AW +: AW]) == a)
                  d[l*W +: W] = wdata[(w*IT + l)*W +: W];
          end
        end
        qv[p].push_back(v); qd[p].push_back(d);
        exp_rvalid[p] = qv[p].pop_front();
        d = qd[p].pop_front();
        if (exp_rvalid[p]) exp_rdata[p] = d;
      end
      cl = !bsy && (waddr[2:0] == waddr[5:3]) && ((wren[3:0] & wren[7:4]) != 0);
      if (bsy) begin
        for (int l = 0; l < IT; l++) mm[DEPTH - busy_cnt][l] = '0;
        busy_cnt--;
      end else begin
        for (int w = 0; w < 2; w++)
          for (int l = 0; l < IT; l++)
            if (wren[w*IT + l]) mm[waddr[w*AW +: AW]][l] = wdata[(w*IT + l)*W +: W];
        if (clear_req) busy_cnt = DEPTH;
      end
      exp_wc = cl;
      if (cl && exp_cnt < 65535) exp_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_on = 0;
  bit cnt_on = 0;
  int rv_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, busy_cnt > 0);
      chk("wcollide", wcollide, exp_wc);
      chk("collide_cnt", collide_cnt, exp_cnt);
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rvalid%0d", p), rvalid[p], exp_rvalid[p]);
        chk($sformatf("rdata%0d", p), rdata[p*32 +: 32], exp_rdata[p]);
      end
    end
    if (cnt_on) for (int p = 0; p < 2; p++) if (rvalid[p]) rv_cnt[p]++;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rden = '0; wren = '0; clear_req = 1'b0;
  endtask

  task automatic rnd(input bit allow_clr);
    rden  = 2'($urandom);
    raddr = 6'($urandom);
    wren  = 8'($urandom);
    waddr = 6'($urandom);
    wdata = {$urandom, $urandom};
    clear_req = allow_clr && ($urandom_range(0, 63) == 0);
  endtask

  task automatic sweep_reads();
    for (int i = 0; i < DEPTH; i++) begin
      rden = 2'b11; raddr = {3'(DEPTH - 1 - i), 3'(i)};
      @(negedge clk);
    end
    idle();
    repeat (L) @(negedge clk);
  endtask

  task automatic count_busy(input bit stir, output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (stir) rnd(1'b0);
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_cnt", collide_cnt, 16'h0);
    chk("rst_busy", busy, 1'b1);

    // 1: clear-on-reset, then read every word
    rstn = 1'b1;
    count_busy(1'b0, n);
    chk("busy_len_reset", n, DEPTH);
    sweep_reads();
    chk("cleared_word", rdata, 64'h0);

    // 2: lane-masked write, read back next cycle
    wren = 8'b0000_0101; waddr = 6'd5; wdata = 64'h0000_0000_000C_000A;
    @(negedge clk);
    idle(); rden = 2'b01; raddr = 6'd5;
    @(negedge clk);
    idle();
    repeat (L - 1) @(negedge clk);
    chk("lit_lane_rvalid", rvalid[0], 1'b1);
    chk("lit_lane_data", rdata[31:0], 32'h000C_000A);

    // 3: write-write collision, port 1 wins
    wren = 8'b0010_0010; waddr = {3'd3, 3'd3};
    wdata = 64'h0;
    wdata[15:8] = 8'h11; wdata[47:40] = 8'h22;
    @(negedge clk);
    idle();
    chk("lit_wcollide", wcollide, 1'b1);
    chk("lit_collide_cnt", collide_cnt, 16'd1);
    rden = 2'b10; raddr = {3'd3, 3'd0};
    @(negedge clk);
    idle();
    repeat (L - 1) @(negedge clk);
    chk("lit_collide_data", rdata[63:32], 32'h0000_2200);

    // 4: same-cycle write/read forwarding
    wren = 8'h01; waddr = 6'd7; wdata = 64'h55;
    rden = 2'b01; raddr = 6'd7;
    @(negedge clk);
    idle();
    repeat (L - 1) @(negedge clk);
    chk("lit_bypass", rdata[31:0], 32'h0000_0055);

    // 5: fill, clear, reset mid-clear, traffic while busy
    for (int i = 0; i < DEPTH; i++) begin
      wren = 8'h0F; waddr = 6'(i); wdata = {$urandom, $urandom};
      @(negedge clk);
    end
    idle(); clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (3) begin rnd(1'b0); @(negedge clk); end
    rstn = 1'b0; rnd(1'b0);
    @(negedge clk);
    rstn = 1'b1;
    count_busy(1'b1, n);
    chk("busy_len_restart", n, DEPTH);
    sweep_reads();
    chk("recleared_word", rdata, 64'h0);

    // 6: back-to-back reads on both ports
    cnt_on = 1;
    for (int i = 0; i < 20; i++) begin
      rnd(1'b0); rden = 2'b11;
      @(negedge clk);
    end
    idle();
    repeat (L) @(negedge clk);
    cnt_on = 0;
    chk("b2b_port0", rv_cnt[0], 20);
    chk("b2b_port1", rv_cnt[1], 20);

    // random soak
    for (int i = 0; i < 600; i++) begin
      rnd(1'b1);
      @(negedge clk);
    end
    idle();
    repeat (L + 1) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
